sram_spi_responder: RTL and testbench

- Synthesizable serial-SRAM target that models the chip on the far side of the CPU memory controller's cs/si/so link.
- Decodes the same frame format the controller sends and answers it: 8-bit command, 24-bit address, 16 data bits.
- Backed by a small internal word array that the bench can also load directly.
- Used as the memory model in CPU simulations and FPGA bring-up. Runs in the clk domain; there is no separate serial clock.

---
 rtl/sram_spi_responder.sv | 214 +++++++++++++++++++++
 tb/tb_sram_spi_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_spi_responder.sv
// -----------------------------------------------------------------------------
// sram_spi_responder
//
// Serial-SRAM target model. Listens on the cs/si/so link, decodes the frame
// (8-bit command, 24-bit byte address MSB first, 16 data bits LSB first) and
// serves READ (0x03) and WRITE (0x02) against an internal 16-bit word array.
// Everything runs in the clk domain; each enabled clk edge with cs low is one
// serial bit.
//
// Optional feature: define SRAM_RESPONDER_SEQ_MODE_EN to let a frame continue
// past the first data word. The frame then streams or accepts consecutive words
// (index+1, wrapping). Without it, bits after the first data word are ignored.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset (sampled only while ena is high)
//   ena         clock enable; low holds all state
//   sram_cs     chip select, active-low
//   sram_si     serial data in from the initiator
//   sram_so     serial data out to the initiator (registered)
//   load_we     backdoor word write strobe
//   load_index  backdoor word index
//   load_data   backdoor word data
//   busy        frame in progress (cs low, past the first bit)
//   bad_cmd     unknown command decoded; held until cs rises
//   wr_strobe   one-cycle pulse after a serial write commits
// -----------------------------------------------------------------------------
module sram_spi_responder #(
    parameter int MEM_WORDS = 256,
    parameter int IDX_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                sram_cs,
    input  logic                sram_si,
    output logic                sram_so,
    input  logic                load_we,
    input  logic [IDX_BITS-1:0] load_index,
    input  logic [15:0]         load_data,
    output logic                busy,
    output logic                bad_cmd,
    output logic                wr_strobe
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam logic [IDX_BITS-1:0] IDX_ONE = {{(IDX_BITS-1){1'b0}}, 1'b1};

    logic [2:0]          state_reg;
    logic [5:0]          bit_cnt_reg;
    logic [6:0]          cmd_sr_reg;
    logic                is_read_reg;
    logic [IDX_BITS-1:0] idx_reg;
    logic [14:0]         rd_sr_reg;
    logic [14:0]         wr_sr_reg;
    logic [15:0]         rd_data_reg;
    logic                so_reg;
    logic                busy_reg;
    logic                bad_cmd_reg;
    logic                wr_strobe_reg;

    logic [15:0]         mem [MEM_WORDS];

    logic [7:0]          cmd_next;
    logic [IDX_BITS-1:0] idx_shifted;
    logic [15:0]         wr_word;
    logic [IDX_BITS-1:0] rd_addr;
    logic                commit;

    assign cmd_next    = {cmd_sr_reg, sram_si};
    // The index register shifts through the whole address; after the bit at
    // n=30 its low IDX_BITS bits are addr[IDX_BITS:1]. Upper address bits
    // simply fall off the top, giving the modulo-MEM_WORDS wrap.
    assign idx_shifted = {idx_reg[IDX_BITS-2:0], sram_si};
    assign wr_word     = {sram_si, wr_sr_reg};

    // Read address: at n=30 the final index is only visible combinationally,
    // so the registered read launches from it and the word is ready at n=31.
    // Otherwise prefetch the following word for sequential streaming.
    assign rd_addr = (bit_cnt_reg == 6'd30) ? idx_shifted : (idx_reg + IDX_ONE);

    assign commit = ena && rst_n && !sram_cs && (state_reg == ST_DATA) &&
                    !is_read_reg && (bit_cnt_reg == 6'd47);

    // Word array: one registered read port, backdoor plus serial write.
    // The serial commit is written last so it wins on a same-index collision.
    always_ff @(posedge clk) begin
        if (ena) begin
            rd_data_reg <= mem[rd_addr];
            if (load_we) begin
                mem[load_index] <= load_data;
            end
            if (commit) begin
                mem[idx_reg] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            if (!rst_n) begin
                state_reg     <= ST_IDLE;
                bit_cnt_reg   <= 6'd0;
                cmd_sr_reg    <= 7'd0;
                is_read_reg   <= 1'b0;
                idx_reg       <= '0;
                rd_sr_reg     <= 15'd0;
                wr_sr_reg     <= 15'd0;
                so_reg        <= 1'b0;
                busy_reg      <= 1'b0;
                bad_cmd_reg   <= 1'b0;
                wr_strobe_reg <= 1'b0;
            end else if (sram_cs) begin
                // Deselect aborts any partial frame; nothing is committed.
                state_reg     <= ST_IDLE;
                bit_cnt_reg   <= 6'd0;
                so_reg        <= 1'b0;
                busy_reg      <= 1'b0;
                bad_cmd_reg   <= 1'b0;
                wr_strobe_reg <= 1'b0;
            end else begin
                busy_reg      <= 1'b1;
                wr_strobe_reg <= 1'b0;
`ifdef SRAM_RESPONDER_SEQ_MODE_EN
                // Data phase repeats: n runs 32..47 for every further word.
                bit_cnt_reg <= (bit_cnt_reg == 6'd47) ? 6'd32 : (bit_cnt_reg + 6'd1);
`else
                bit_cnt_reg <= (bit_cnt_reg == 6'd48) ? 6'd48 : (bit_cnt_reg + 6'd1);
`endif
                case (state_reg)
                    ST_IDLE: begin
                        cmd_sr_reg <= cmd_next[6:0];
                        state_reg  <= ST_CMD;
                    end
                    ST_CMD: begin
                        cmd_sr_reg <= cmd_next[6:0];
                        if (bit_cnt_reg == 6'd7) begin
                            if (cmd_next == CMD_READ) begin
                                is_read_reg <= 1'b1;
                                state_reg   <= ST_ADDR;
                            end else if (cmd_next == CMD_WRITE) begin
                                is_read_reg <= 1'b0;
                                state_reg   <= ST_ADDR;
                            end else begin
                                bad_cmd_reg <= 1'b1;
                                state_reg   <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (bit_cnt_reg == 6'd31) begin
                            // Address bit 0 is ignored; data bit 0 goes out now.
                            state_reg <= ST_DATA;
                            rd_sr_reg <= rd_data_reg[15:1];
                            so_reg    <= is_read_reg & rd_data_reg[0];
                        end else begin
                            idx_reg <= idx_shifted;
                        end
                    end
                    ST_DATA: begin
                        if (is_read_reg) begin
                            if (bit_cnt_reg == 6'd47) begin
`ifdef SRAM_RESPONDER_SEQ_MODE_EN
                                so_reg    <= rd_data_reg[0];
                                rd_sr_reg <= rd_data_reg[15:1];
                                idx_reg   <= idx_reg + IDX_ONE;
`else
                                so_reg    <= 1'b0;
                                state_reg <= ST_DONE;
`endif
                            end else begin
                                so_reg    <= rd_sr_reg[0];
                                rd_sr_reg <= {1'b0, rd_sr_reg[14:1]};
                            end
                        end else begin
                            so_reg    <= 1'b0;
                            wr_sr_reg <= wr_word[15:1];
                            if (bit_cnt_reg == 6'd47) begin
                                wr_strobe_reg <= 1'b1;
`ifdef SRAM_RESPONDER_SEQ_MODE_EN
                                idx_reg <= idx_reg + IDX_ONE;
`else
                                state_reg <= ST_DONE;
`endif
                            end
                        end
                    end
                    ST_DONE, ST_IGNORE: begin
                        so_reg <= 1'b0;
                    end
                    default: begin
                        so_reg    <= 1'b0;
                        state_reg <= ST_IGNORE;
                    end
                endcase
            end
        end
    end

    assign sram_so   = so_reg;
    assign busy      = busy_reg;
    assign bad_cmd   = bad_cmd_reg;
    assign wr_strobe = wr_strobe_reg;

endmodule

// File: tb/tb_sram_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_spi_responder
//
// Directed bench for sram_spi_responder: backdoor loads, read/write frames,
// aborted write, unknown command, address aliasing, same-edge write collision
// and the multi-word read (expectation depends on SRAM_RESPONDER_SEQ_MODE_EN).
// -----------------------------------------------------------------------------
module tb_sram_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        sram_cs = 1'b1;
    logic        sram_si = 1'b0;
    logic        sram_so;
    logic        load_we = 1'b0;
    logic [7:0]  load_index = 8'd0;
    logic [15:0] load_data = 16'd0;
    logic        busy;
    logic        bad_cmd;
    logic        wr_strobe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_spi_responder #(.MEM_WORDS(256), .IDX_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sram_cs    (sram_cs),
        .sram_si    (sram_si),
        .sram_so    (sram_so),
        .load_we    (load_we),
        .load_index (load_index),
        .load_data  (load_data),
        .busy       (busy),
        .bad_cmd    (bad_cmd),
        .wr_strobe  (wr_strobe)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] idx, input logic [15:0] data);
        load_we    = 1'b1;
        load_index = idx;
        load_data  = data;
        tick();
        load_we = 1'b0;
    endtask

    // Drives one frame of nbits bits; bits from n=32 on cycle through wdata
    // LSB first. sram_so bits after edges n=31..62 are collected into rd.
    task automatic run_frame(
        input  logic [7:0]  cmd,
        input  logic [23:0] addr,
        input  logic [15:0] wdata,
        input  int          nbits,
        input  int          load_at,
        input  logic [7:0]  l_idx,
        input  logic [15:0] l_data,
        output logic [31:0] rd,
        output int          strobes,
        output int          strobe_at,
        output int          bad_at,
        output logic        busy_ok,
        output logic        so_any,
        output logic        post_idle
    );
        rd = 32'd0;
        strobes = 0;
        strobe_at = -1;
        bad_at = -1;
        busy_ok = 1'b1;
        so_any = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 8)       sram_si = cmd[7-i];
            else if (i < 32) sram_si = addr[31-i];
            else             sram_si = wdata[(i-32)%16];
            sram_cs = 1'b0;
            if (i == load_at) begin
                load_we    = 1'b1;
                load_index = l_idx;
                load_data  = l_data;
            end
            tick();
            load_we = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (sram_so === 1'b1) so_any = 1'b1;
            if (bad_cmd === 1'b1 && bad_at < 0) bad_at = i;
            if (wr_strobe === 1'b1) begin
                strobes++;
                if (strobe_at < 0) strobe_at = i;
            end
            if (i >= 31 && i <= 62) rd[i-31] = sram_so;
        end
        sram_cs = 1'b1;
        sram_si = 1'b0;
        tick();
        if (wr_strobe === 1'b1) strobes++;
        post_idle = (busy === 1'b0) && (bad_cmd === 1'b0) && (sram_so === 1'b0);
        tick();
    endtask

    logic [31:0] rd;
    int          strobes, strobe_at, bad_at;
    logic        busy_ok, so_any, post_idle;
    logic [31:0] seq_exp;

    initial begin
        // Reset with backdoor loads honoured during reset.
        rst_n = 1'b0;
        tick();
        load_word(8'h80, 16'hBEEF);
        load_word(8'h82, 16'h0000);
        load_word(8'h83, 16'h5555);
        load_word(8'h84, 16'h0000);
        load_word(8'hFF, 16'hCAFE);
        load_word(8'h00, 16'h1357);
        check_val("rst_so",        {31'd0, sram_so},   32'd0);
        check_val("rst_busy",      {31'd0, busy},      32'd0);
        check_val("rst_bad_cmd",   {31'd0, bad_cmd},   32'd0);
        check_val("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Read of backdoor-loaded word.
        run_frame(8'h03, 24'h000100, 16'h0000, 48, -1, 8'h00, 16'h0000,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("rd100_data",   {16'd0, rd[15:0]}, 32'h0000BEEF);
        check_val("rd100_busy",   {31'd0, busy_ok},  32'd1);
        check_val("rd100_badcmd", bad_at,            -1);
        check_val("rd100_idle",   {31'd0, post_idle}, 32'd1);

        // Write then read back.
        run_frame(8'h02, 24'h000104, 16'h1234, 48, -1, 8'h00, 16'h0000,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("wr104_strobes",   strobes,   1);
        check_val("wr104_strobe_at", strobe_at, 47);
        run_frame(8'h03, 24'h000104, 16'h0000, 48, -1, 8'h00, 16'h0000,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("rd104_data", {16'd0, rd[15:0]}, 32'h00001234);

        // Aborted write: cs rises before bit 40.
        run_frame(8'h02, 24'h000106, 16'hFFFF, 40, -1, 8'h00, 16'h0000,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("abort_strobes", strobes, 0);
        run_frame(8'h03, 24'h000106, 16'h0000, 48, -1, 8'h00, 16'h0000,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("abort_rd106", {16'd0, rd[15:0]}, 32'h00005555);

        // Unknown command.
        run_frame(8'h05, 24'h000100, 16'hFFFF, 48, -1, 8'h00, 16'h0000,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("bad_at",      bad_at,                 7);
        check_val("bad_so_zero", {31'd0, so_any},         32'd0);
        check_val("bad_strobes", strobes,                 0);
        check_val("bad_cleared", {31'd0, post_idle},      32'd1);
        run_frame(8'h03, 24'h000100, 16'h0000, 48, -1, 8'h00, 16'h0000,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("bad_mem_kept", {16'd0, rd[15:0]}, 32'h0000BEEF);

        // Address aliasing: 0x000300 -> index 0x80.
        run_frame(8'h03, 24'h000300, 16'h0000, 48, -1, 8'h00, 16'h0000,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("alias_rd300", {16'd0, rd[15:0]}, 32'h0000BEEF);

        // Same-edge backdoor and serial commit to index 0x84.
        run_frame(8'h02, 24'h000108, 16'hA5A5, 48, 47, 8'h84, 16'h1111,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("coll_strobes", strobes, 1);
        run_frame(8'h03, 24'h000108, 16'h0000, 48, -1, 8'h00, 16'h0000,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("coll_rd108", {16'd0, rd[15:0]}, 32'h0000A5A5);

        // Two-word read across the index wrap (0xFF then 0x00).
`ifdef SRAM_RESPONDER_SEQ_MODE_EN
        seq_exp = 32'h1357CAFE;
`else
        seq_exp = 32'h0000CAFE;
`endif
        run_frame(8'h03, 24'h0001FE, 16'h0000, 64, -1, 8'h00, 16'h0000,
                  rd, strobes, strobe_at, bad_at, busy_ok, so_any, post_idle);
        check_val("seq_rd1fe", rd, seq_exp);
        check_val("seq_busy",  {31'd0, busy_ok}, 32'd1);

        // ena low: cs low edges are not sampled, busy stays low.
        ena = 1'b0;
        sram_cs = 1'b0;
        sram_si = 1'b1;
        repeat (3) tick();
        check_val("ena_hold_busy", {31'd0, busy}, 32'd0);
        sram_cs = 1'b1;
        ena = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
